// File: rtl/calc_sequencer.sv
// RPN calculator sequencer: turns decoded keys into stack commands and divider launches.
// One EXEC cycle per key (divide waits for div_done); keys are only taken in IDLE or ERR.
module calc_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         key_valid,
  input  logic [3:0]                   key_code,
  output logic                         key_ready,
  input  logic [WIDTH-1:0]             stk_top,
  input  logic [WIDTH-1:0]             stk_next,
  input  logic [$clog2(DEPTH+1)-1:0]   stk_count,
  output logic [1:0]                   stk_cmd,
  output logic [WIDTH-1:0]             stk_data,
  output logic                         div_start,
  output logic [WIDTH-1:0]             div_a,
  output logic [WIDTH-1:0]             div_b,
  input  logic                         div_done,
  input  logic [WIDTH-1:0]             div_quot,
  output logic                         busy,
  output logic                         error
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [1:0] CMD_NOP      = 2'b00;
  localparam logic [1:0] CMD_WRITE    = 2'b01;
  localparam logic [1:0] CMD_PUSH     = 2'b10;
  localparam logic [1:0] CMD_POPWRITE = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, DIV_WAIT, ERR} state_t;

  state_t          state, state_nxt;
  logic [3:0]      key_q;
  logic            accept;
  logic            too_few;
  logic [WIDTH-1:0] top_x10;
  logic [WIDTH-1:0] digit;

  assign key_ready = (state == IDLE) || (state == ERR);
  assign accept    = key_valid && key_ready;
  assign busy      = (state != IDLE);
  assign error     = (state == ERR);
  assign too_few   = (stk_count < CW'(2));
  assign top_x10   = stk_top * WIDTH'(10);
  assign digit     = WIDTH'(key_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      key_q <= '0;
    end else begin
      state <= state_nxt;
      // A key accepted in ERR only clears the error, so it is not latched.
      if (state == IDLE && accept)
        key_q <= key_code;
    end
  end

  always_comb begin
    state_nxt = state;
    stk_cmd   = CMD_NOP;
    stk_data  = '0;
    div_start = 1'b0;
    div_a     = '0;
    div_b     = '0;
    case (state)
      IDLE: begin
        if (accept)
          state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = IDLE;
        case (key_q)
          4'hA: begin
            if (stk_count == FULL_COUNT) begin
              state_nxt = ERR;
            end else begin
              stk_cmd = CMD_PUSH;
            end
          end
          4'hB, 4'hC, 4'hD: begin
            if (too_few) begin
              state_nxt = ERR;
            end else begin
              stk_cmd = CMD_POPWRITE;
              if (key_q == 4'hB)
                stk_data = stk_next + stk_top;
              else if (key_q == 4'hC)
                stk_data = stk_next - stk_top;
              else
                stk_data = stk_next * stk_top;
            end
          end
          4'hE: begin
            if (too_few || stk_top == '0) begin
              state_nxt = ERR;
            end else begin
              div_start = 1'b1;
              div_a     = stk_next;
              div_b     = stk_top;
              state_nxt = DIV_WAIT;
            end
          end
          4'hF: begin
            stk_cmd  = CMD_WRITE;
            stk_data = '0 - stk_top;
          end
          default: begin
            // Digits extend the magnitude, so a negative entry grows more negative.
            stk_cmd  = CMD_WRITE;
            stk_data = stk_top[WIDTH-1] ? (top_x10 - digit) : (top_x10 + digit);
          end
        endcase
      end
      DIV_WAIT: begin
        if (div_done) begin
          stk_cmd   = CMD_POPWRITE;
          stk_data  = div_quot;
          state_nxt = IDLE;
        end
      end
      ERR: begin
        if (accept)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed vector table, hand-written divide/reset sequences,
// and randomized keys checked against an arithmetic reference model.
module tb_calc_sequencer;

  logic        clock, reset;
  logic        key_valid, key_ready;
  logic [3:0]  key_code;
  logic [31:0] stk_top, stk_next, stk_data, div_a, div_b, div_quot;
  logic [3:0]  stk_count;
  logic [1:0]  stk_cmd;
  logic        div_start, div_done, busy, error;

  int total = 0;
  int passed = 0;

  calc_sequencer #(.WIDTH(32), .DEPTH(8)) dut (
    .clock(clock), .reset(reset),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .stk_top(stk_top), .stk_next(stk_next), .stk_count(stk_count),
    .stk_cmd(stk_cmd), .stk_data(stk_data),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_quot(div_quot),
    .busy(busy), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  key;
    logic [31:0] top;
    logic [31:0] nxt;
    int          cnt;
    logic [1:0]  cmd;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference behaviour from the key definitions, in wide signed arithmetic.
  function automatic void model(input logic [3:0] k, input logic [31:0] top, input logic [31:0] nxt,
                                input int cnt, output logic [1:0] cmd, output logic [31:0] data,
                                output logic err);
    longint t = longint'($signed(top));
    longint n = longint'($signed(nxt));
    longint r = 0;
    int d = int'(k);
    cmd = 2'b00;
    err = 1'b0;
    if (d <= 9) begin
      r = (t >= 0) ? t * 10 + d : t * 10 - d;
      cmd = 2'b01;
    end else if (d == 10) begin
      if (cnt == 8) err = 1'b1; else cmd = 2'b10;
    end else if (d == 15) begin
      r = -t;
      cmd = 2'b01;
    end else if (cnt < 2 || (d == 14 && t == 0)) begin
      err = 1'b1;
    end else begin
      cmd = 2'b11;
      case (d)
        11: r = n + t;
        12: r = n - t;
        13: r = n * t;
        default: r = n / t;
      endcase
    end
    data = r[31:0];
  endfunction

  // Entered just after a rising edge; leaves just after a rising edge with the DUT idle.
  task automatic do_key(input logic [3:0] k, input logic [31:0] top, input logic [31:0] nxt,
                        input int cnt, input logic [1:0] e_cmd, input logic [31:0] e_data,
                        input logic e_err, input int div_lat);
    stk_top = top; stk_next = nxt; stk_count = cnt[3:0];
    key_code = k; key_valid = 1'b1;
    #1 chk("ready_idle", key_ready, 1'b1);
    @(posedge clock); #1;
    key_valid = 1'b0;
    chk("busy_exec", busy, 1'b1);
    if (k == 4'hE && !e_err) begin
      chk("div_start", div_start, 1'b1);
      chk("div_a", div_a, nxt);
      chk("div_b", div_b, top);
      chk("cmd_exec_div", stk_cmd, 2'b00);
      for (int i = 0; i < div_lat - 1; i++) begin
        @(posedge clock); #1;
        chk("wait_cmd", stk_cmd, 2'b00);
        chk("wait_start", div_start, 1'b0);
        chk("wait_ready", key_ready, 1'b0);
      end
      @(posedge clock); #1;
      div_done = 1'b1; div_quot = e_data;
      #1;
      chk("div_cmd", stk_cmd, e_cmd);
      chk("div_data", stk_data, e_data);
      @(posedge clock); #1;
      div_done = 1'b0;
      chk("div_idle", busy, 1'b0);
    end else begin
      chk("cmd", stk_cmd, e_cmd);
      if (!e_err) chk("data", stk_data, e_data);
      chk("no_start", div_start, 1'b0);
      @(posedge clock); #1;
      chk("error", error, e_err);
      if (e_err) begin
        chk("err_cmd", stk_cmd, 2'b00);
        chk("err_ready", key_ready, 1'b1);
        key_code = 4'h1; key_valid = 1'b1;
        @(posedge clock); #1;
        key_valid = 1'b0;
        chk("err_clear", error, 1'b0);
        chk("clear_cmd", stk_cmd, 2'b00);
        chk("clear_busy", busy, 1'b0);
      end else begin
        chk("busy_after", busy, 1'b0);
        chk("cmd_after", stk_cmd, 2'b00);
      end
    end
  endtask

  initial begin
    logic [1:0]  m_cmd;
    logic [31:0] m_data, rt, rn;
    logic        m_err;
    logic [3:0]  rk;

    tbl[0]  = '{4'h1, 32'd0,          32'd0,   1, 2'b01, 32'd1,          1'b0};
    tbl[1]  = '{4'h2, 32'd1,          32'd0,   1, 2'b01, 32'd12,         1'b0};
    tbl[2]  = '{4'h3, 32'd12,         32'd0,   1, 2'b01, 32'd123,        1'b0};
    tbl[3]  = '{4'hB, 32'd900,        32'd123, 2, 2'b11, 32'd1023,       1'b0};
    tbl[4]  = '{4'hF, 32'd5,          32'd0,   1, 2'b01, 32'hFFFFFFFB,   1'b0};
    tbl[5]  = '{4'hB, 32'h7FFFFFFF,   32'd1,   2, 2'b11, 32'h80000000,   1'b0};
    tbl[6]  = '{4'hC, 32'd3,          32'd10,  3, 2'b11, 32'd7,          1'b0};
    tbl[7]  = '{4'hD, 32'hFFFFFFFC,   32'd6,   2, 2'b11, 32'hFFFFFFE8,   1'b0};
    tbl[8]  = '{4'h5, 32'hFFFFFFF4,   32'd0,   1, 2'b01, 32'hFFFFFF83,   1'b0};
    tbl[9]  = '{4'hA, 32'd9,          32'd0,   7, 2'b10, 32'd0,          1'b0};
    tbl[10] = '{4'hB, 32'd1,          32'd0,   1, 2'b00, 32'd0,          1'b1};
    tbl[11] = '{4'hE, 32'd0,          32'd5,   2, 2'b00, 32'd0,          1'b1};
    tbl[12] = '{4'hA, 32'd0,          32'd0,   8, 2'b00, 32'd0,          1'b1};
    tbl[13] = '{4'hD, 32'd2,          32'd2,   1, 2'b00, 32'd0,          1'b1};
    tbl[14] = '{4'h9, 32'd0,          32'd0,   1, 2'b01, 32'd9,          1'b0};

    reset = 1'b1; key_valid = 1'b0; key_code = '0;
    stk_top = '0; stk_next = '0; stk_count = 4'd1;
    div_done = 1'b0; div_quot = '0;
    #1;
    chk("rst_cmd", stk_cmd, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_start", div_start, 1'b0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    #1 chk("rst_ready", key_ready, 1'b1);
    @(posedge clock); #1;

    foreach (tbl[i])
      do_key(tbl[i].key, tbl[i].top, tbl[i].nxt, tbl[i].cnt, tbl[i].cmd, tbl[i].data, tbl[i].err, 1);

    // Divide with a slow divider: -1184 / -5 truncates to 236.
    do_key(4'hE, 32'hFFFFFFFB, -32'sd1184, 2, 2'b11, 32'd236, 1'b0, 7);

    // Key held during DIV_WAIT, then reset abandons the division.
    stk_top = 32'd7; stk_next = 32'd21; stk_count = 4'd2;
    key_code = 4'hE; key_valid = 1'b1;
    @(posedge clock); #1;
    key_code = 4'h3;
    chk("t5_start", div_start, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      chk("t5_ready", key_ready, 1'b0);
      chk("t5_busy", busy, 1'b1);
      chk("t5_cmd", stk_cmd, 2'b00);
    end
    reset = 1'b1;
    #1;
    key_valid = 1'b0;
    chk("t5_rst_cmd", stk_cmd, 2'b00);
    chk("t5_rst_data", stk_data, 32'd0);
    chk("t5_rst_start", div_start, 1'b0);
    chk("t5_rst_a", div_a, 32'd0);
    chk("t5_rst_b", div_b, 32'd0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_err", error, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1 chk("t5_rel_ready", key_ready, 1'b1);
    div_done = 1'b1; div_quot = 32'd99;
    #1;
    chk("t5_late_cmd", stk_cmd, 2'b00);
    @(posedge clock); #1;
    div_done = 1'b0;
    chk("t5_late_busy", busy, 1'b0);
    chk("t5_late_cmd2", stk_cmd, 2'b00);

    for (int n = 0; n < 150; n++) begin
      rk = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) rt = $urandom(); else rt = 32'($urandom_range(0, 20)) - 32'd10;
      if ($urandom_range(0, 1) == 1) rn = $urandom(); else rn = 32'($urandom_range(0, 200)) - 32'd100;
      begin
        int cnt;
        cnt = int'($urandom_range(1, 8));
        model(rk, rt, rn, cnt, m_cmd, m_data, m_err);
        do_key(rk, rt, rn, cnt, m_cmd, m_data, m_err, int'($urandom_range(1, 5)));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
